sr_flip_flop: RTL and testbench
===============================

Name: sr_flip_flop

Overview:
- Clocked SR flip-flop (bank of WIDTH independent bits) with complementary outputs and synchronous active-low reset.
- Used as a basic storage/flag element in control paths.
- Resolves the forbidden S=R=1 input by a parameterised policy and reports it on a registered error flag.

Parameters:
- WIDTH, 1, number of independent SR bits; s, r, q, qn, invalid are all WIDTH wide.
- INVALID_MODE, 0, S=R=1 policy per bit: 0 = hold, 1 = set wins, 2 = reset wins, 3 = toggle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- s  input  WIDTH  set request per bit.
- r  input  WIDTH  reset request per bit.
- q  output  WIDTH  stored state.
- qn  output  WIDTH  complement of q.
- invalid  output  WIDTH  per-bit flag: S=R=1 was sampled at the last edge.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset: rst_n=0 at a posedge gives q=0, qn=all ones, invalid=0. Reset overrides s and r. There is no asynchronous path.
- Per bit at each posedge with rst_n=1:
  - S=0, R=0: hold.
  - S=1, R=0: q=1.
  - S=0, R=1: q=0.
  - S=1, R=1: apply INVALID_MODE.
- Latency: inputs are sampled only at the rising edge. q changes one clock after the edge that samples the request (visible right after that edge). Input changes between edges have no effect.
- qn is always exactly ~q, including during and after reset. It is derived combinationally from the q register, never stored separately, so q==qn never occurs.
- invalid[i] is registered: set to 1 for exactly the cycle following an edge that sampled s[i]=r[i]=1, otherwise 0. It is cleared by reset.
- Bits are fully independent; no cross-bit interaction.
- Unsupported INVALID_MODE values (>3) behave as 0 (hold).
- Reset asserted in the same cycle as a set request: reset wins, q=0.
- Before the first reset edge, q is X (no initial value is required). Benches must reset first.

Optional Feature:
- Macro SR_FLIP_FLOP_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (16 bits, unsigned) counting posedges at which any bit sampled S=R=1 with rst_n=1. One count per edge regardless of how many bits are invalid.
  - The counter saturates at 0xFFFF (no wrap) and is cleared to 0 by reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with s=1,r=0 -> q=0, qn=1, invalid=0 after each edge.
- Set/hold (clk period 10, posedges at 5,15,25...): s=1,r=0 applied at t=12, back to 0/0 at t=22 -> q=1, qn=0 from the t=15 edge, still held after the t=25 and t=35 edges.
- Reset request: s=0,r=1 at t=34, 0/0 at t=44 -> q=0, qn=1 from the t=35 edge, held afterwards. Also repeat with reset wins: rst_n=0 and s=1 on the same edge -> q=0.
- Invalid, INVALID_MODE=0: from q=0, s=r=1 for one edge -> q stays 0, invalid=1 for one cycle, then invalid returns to 0 with s=r=0. Repeat for modes 1/2/3 from q=0 -> q=1/0/1 respectively. A second mode-3 edge gives q=0.
- Multi-bit, WIDTH=4: s=4'b0101, r=4'b1010 from reset -> q=4'b0101, qn=4'b1010. Then s=4'b1000, r=4'b1000 (mode 0) -> q=4'b0101, invalid=4'b1000.
- SR_FLIP_FLOP_ERR_CNT_EN defined: 3 edges with S=R=1 on one bit -> err_cnt=3. After reset -> err_cnt=0. Preload near max (force 0xFFFE) plus 3 invalid edges -> err_cnt=0xFFFF.

Source files
------------

// File: rtl/sr_flip_flop.sv
// sr_flip_flop: bank of WIDTH independent clocked SR flip-flops.
//
// Each bit is set by s, cleared by r and otherwise holds its value. When s and
// r are both high on the same edge, INVALID_MODE decides what happens:
//   0 = hold, 1 = set wins, 2 = reset wins, 3 = toggle.
//   Any value above 3 behaves as hold.
// The registered invalid flag goes high for the one cycle that follows such an
// edge.
//
// Ports
//   clk      input          clock; all state changes on the rising edge
//   rst_n    input          synchronous reset, active low; overrides s and r
//   s        input  [W-1:0] set request per bit
//   r        input  [W-1:0] reset request per bit
//   q        output [W-1:0] stored state
//   qn       output [W-1:0] complement of q, derived from the q register
//   invalid  output [W-1:0] s=r=1 was sampled at the last edge
//   err_cnt  output [15:0]  only with SR_FLIP_FLOP_ERR_CNT_EN defined:
//                           saturating count of edges where any bit saw s=r=1
//
// Optional feature macro: SR_FLIP_FLOP_ERR_CNT_EN (undefined by default).
module sr_flip_flop #(
  parameter int WIDTH        = 1,
  parameter int INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] invalid
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] invalid_q;
  logic [WIDTH-1:0] invalid_d;

  always_comb begin
    q_d       = q_q;
    invalid_d = s & r;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b10: q_d[i] = 1'b1;
        2'b01: q_d[i] = 1'b0;
        2'b11: begin
          case (INVALID_MODE)
            1:       q_d[i] = 1'b1;
            2:       q_d[i] = 1'b0;
            3:       q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= '0;
      invalid_q <= '0;
    end else begin
      q_q       <= q_d;
      invalid_q <= invalid_d;
    end
  end

  // qn comes straight from q_q so the two outputs can never agree.
  assign q       = q_q;
  assign qn      = ~q_q;
  assign invalid = invalid_q;

`ifdef SR_FLIP_FLOP_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  // One count per edge no matter how many bits are invalid; sticks at 0xFFFF.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((|(s & r)) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
module tb_sr_flip_flop;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s1, r1;
  logic [3:0] s4, r4;

  logic q_m0, qn_m0, inv_m0;
  logic q_m1, qn_m1, inv_m1;
  logic q_m2, qn_m2, inv_m2;
  logic q_m3, qn_m3, inv_m3;
  logic q_m5, qn_m5, inv_m5;
  logic [3:0] q_w4, qn_w4, inv_w4;
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
  logic [15:0] cnt_m0, cnt_m1, cnt_m2, cnt_m3, cnt_m5, cnt_w4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m0), .qn(qn_m0), .invalid(inv_m0)
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    , .err_cnt(cnt_m0)
`endif
  );
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m1), .qn(qn_m1), .invalid(inv_m1)
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    , .err_cnt(cnt_m1)
`endif
  );
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(2)) dut_m2 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m2), .qn(qn_m2), .invalid(inv_m2)
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    , .err_cnt(cnt_m2)
`endif
  );
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(3)) dut_m3 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m3), .qn(qn_m3), .invalid(inv_m3)
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    , .err_cnt(cnt_m3)
`endif
  );
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(5)) dut_m5 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m5), .qn(qn_m5), .invalid(inv_m5)
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    , .err_cnt(cnt_m5)
`endif
  );
  sr_flip_flop #(.WIDTH(4), .INVALID_MODE(0)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .q(q_w4), .qn(qn_w4), .invalid(inv_w4)
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    , .err_cnt(cnt_w4)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       s1;
    logic       r1;
    logic [3:0] s4;
    logic [3:0] r4;
    logic [4:0] q1;    // expected q for modes {5,3,2,1,0}, bit 0 = mode 0
    logic       inv1;  // expected invalid on every single-bit instance
    logic [3:0] q4;
    logic [3:0] inv4;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_single(input logic [4:0] eq, input logic einv);
    logic [4:0] act_q, act_qn, act_inv;
    act_q   = {q_m5, q_m3, q_m2, q_m1, q_m0};
    act_qn  = {qn_m5, qn_m3, qn_m2, qn_m1, qn_m0};
    act_inv = {inv_m5, inv_m3, inv_m2, inv_m1, inv_m0};
    check("q_modes", {11'd0, act_q}, {11'd0, eq});
    check("qn_modes", {11'd0, act_qn}, {11'd0, ~eq});
    check("invalid_modes", {11'd0, act_inv}, {11'd0, {5{einv}}});
  endtask

  task automatic set_vec(input int idx, input logic rn, input logic s, input logic r,
                         input logic [3:0] sw, input logic [3:0] rw, input logic [4:0] eq,
                         input logic einv, input logic [3:0] eq4, input logic [3:0] einv4);
    vecs[idx].rst_n = rn;  vecs[idx].s1 = s;     vecs[idx].r1 = r;
    vecs[idx].s4    = sw;  vecs[idx].r4 = rw;    vecs[idx].q1 = eq;
    vecs[idx].inv1  = einv; vecs[idx].q4 = eq4;  vecs[idx].inv4 = einv4;
  endtask

`ifdef SR_FLIP_FLOP_ERR_CNT_EN
  logic [15:0] exp_cnt;
`endif

  initial begin
    rst_n = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'hF; r4 = 4'h0;

    //         rst s  r  s4       r4       q{5,3,2,1,0} inv q4       inv4
    set_vec( 0, 0, 1, 0, 4'b1111, 4'b0000, 5'b00000, 0, 4'b0000, 4'b0000);
    set_vec( 1, 0, 1, 0, 4'b1111, 4'b0000, 5'b00000, 0, 4'b0000, 4'b0000);
    set_vec( 2, 1, 1, 0, 4'b0101, 4'b1010, 5'b11111, 0, 4'b0101, 4'b0000);
    set_vec( 3, 1, 0, 0, 4'b1000, 4'b1000, 5'b11111, 0, 4'b0101, 4'b1000);
    set_vec( 4, 1, 0, 0, 4'b0000, 4'b0000, 5'b11111, 0, 4'b0101, 4'b0000);
    set_vec( 5, 1, 0, 1, 4'b0000, 4'b1111, 5'b00000, 0, 4'b0000, 4'b0000);
    set_vec( 6, 1, 0, 0, 4'b0011, 4'b0011, 5'b00000, 0, 4'b0000, 4'b0011);
    set_vec( 7, 1, 1, 1, 4'b0000, 4'b0000, 5'b01010, 1, 4'b0000, 4'b0000);
    set_vec( 8, 1, 0, 0, 4'b0000, 4'b0000, 5'b01010, 0, 4'b0000, 4'b0000);
    set_vec( 9, 1, 1, 1, 4'b0000, 4'b0000, 5'b00010, 1, 4'b0000, 4'b0000);
    set_vec(10, 1, 1, 1, 4'b0000, 4'b0000, 5'b01010, 1, 4'b0000, 4'b0000);
    set_vec(11, 0, 1, 1, 4'b1111, 4'b1111, 5'b00000, 0, 4'b0000, 4'b0000);
    set_vec(12, 0, 1, 0, 4'b1111, 4'b0000, 5'b00000, 0, 4'b0000, 4'b0000);
    set_vec(13, 1, 1, 0, 4'b1111, 4'b0000, 5'b11111, 0, 4'b1111, 4'b0000);
    set_vec(14, 1, 1, 1, 4'b1111, 4'b1111, 5'b10011, 1, 4'b1111, 4'b1111);

`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    exp_cnt = 16'd0;
`endif

    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n;
      s1 = vecs[i].s1; r1 = vecs[i].r1;
      s4 = vecs[i].s4; r4 = vecs[i].r4;
      @(posedge clk);
      #1;
      check_single(vecs[i].q1, vecs[i].inv1);
      check("q_w4", {12'd0, q_w4}, {12'd0, vecs[i].q4});
      check("qn_w4", {12'd0, qn_w4}, {12'd0, ~vecs[i].q4});
      check("invalid_w4", {12'd0, inv_w4}, {12'd0, vecs[i].inv4});
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
      if (!vecs[i].rst_n) exp_cnt = 16'd0;
      else if (vecs[i].s1 && vecs[i].r1) exp_cnt = exp_cnt + 16'd1;
      check("err_cnt_m0", cnt_m0, exp_cnt);
`endif
      #3;
    end

    // Mid-cycle glitch: a set pulse that is gone before the next edge does nothing.
    rst_n = 1'b0; s1 = 1'b0; r1 = 1'b0; s4 = 4'h0; r4 = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    s1 = 1'b1; s4 = 4'hF;
    #1;
    check("no_comb_path_q", {15'd0, q_m0}, 16'd0);
    #2;
    s1 = 1'b0; s4 = 4'h0;
    @(posedge clk); #1;
    check("glitch_ignored_q", {15'd0, q_m0}, 16'd0);
    check("glitch_ignored_w4", {12'd0, q_w4}, 16'd0);

    // Set at t+2 after an edge, cleared one cycle later: q rises at the next edge and holds.
    #1; s1 = 1'b1;
    @(posedge clk); #1;
    check("set_latency_q", {15'd0, q_m0}, 16'd1);
    s1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("set_hold_q", {15'd0, q_m0}, 16'd1);
      check("set_hold_qn", {15'd0, qn_m0}, 16'd0);
    end

`ifdef SR_FLIP_FLOP_ERR_CNT_EN
    // Saturation: preload near max, then three invalid edges.
    rst_n = 1'b0; s1 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1;
    check("err_cnt_reset", cnt_m0, 16'd0);
    rst_n = 1'b1;
    force dut_m0.err_cnt_q = 16'hFFFE;
    #1;
    release dut_m0.err_cnt_q;
    s1 = 1'b1; r1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("err_cnt_saturate", cnt_m0, 16'hFFFF);
    end
    s1 = 1'b0; r1 = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
